// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered WIDTH-bit bitwise logic unit with an
// accumulator feedback path, a one-deep output register behind a
// valid/ready handshake, zero/parity flags and an accepted-op counter.
module logic_unit_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             acc_clear,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_parity;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_op_count;

  logic             w_accept;
  logic [WIDTH-1:0] w_beff;
  logic [WIDTH-1:0] w_f;

  // One-bit slice of the operation table; every op is purely bitwise,
  // so the full result is just WIDTH independent copies of this.
  function automatic logic bit_op(input logic [2:0] sel, input logic a, input logic b);
    case (sel)
      3'b000:  bit_op = a & b;
      3'b001:  bit_op = a | b;
      3'b010:  bit_op = a ^ b;
      3'b011:  bit_op = ~(a | b);
      3'b100:  bit_op = ~(a & b);
      3'b101:  bit_op = ~(a ^ b);
      3'b110:  bit_op = ~a;
      default: bit_op = a;
    endcase
  endfunction

  // Ready depends only on the output register state and the consumer,
  // never on in_valid or operand data.
  assign in_ready = !r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready;

  // A clear on the same cycle as an accumulator-mode accept feeds zero.
  assign w_beff = acc_mode ? (acc_clear ? '0 : r_acc) : B;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign w_f[gi] = bit_op(op, A[gi], w_beff[gi]);
    end
  endgenerate

  // Output register, flags, accumulator and counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_parity    <= 1'b0;
      r_acc       <= '0;
      r_op_count  <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_result    <= w_f;
        r_zero      <= (w_f == '0);
        r_parity    <= ^w_f;
        r_acc       <= w_f;
        r_op_count  <= r_op_count + 1'b1;
      end else begin
        if (out_ready) begin
          r_out_valid <= 1'b0;
        end
        if (acc_clear) begin
          r_acc <= '0;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign parity    = r_parity;
  assign acc       = r_acc;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed steps from the
// functional description followed by randomized traffic, both checked
// against a transaction-level reference model. A second instance with a
// 2-bit counter shares the stimulus to exercise counter wrap.
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_ready2;
  logic [2:0] op;
  logic       acc_mode;
  logic       acc_clear;
  logic [3:0] A;
  logic [3:0] B;
  logic       out_valid, out_valid2;
  logic       out_ready;
  logic [3:0] result, result2;
  logic       zero, zero2;
  logic       parity, parity2;
  logic [3:0] acc, acc2;
  logic [7:0] op_count;
  logic [1:0] op_count2;

  int total = 0;
  int bad = 0;

  // Reference model state
  bit         m_known = 0;
  bit         m_valid;
  bit [3:0]   m_result;
  bit         m_zero;
  bit         m_parity;
  bit [3:0]   m_acc;
  int         m_cnt;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .acc_mode(acc_mode), .acc_clear(acc_clear), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .parity(parity), .acc(acc), .op_count(op_count)
  );

  logic_unit_pipe #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .op(op), .acc_mode(acc_mode), .acc_clear(acc_clear), .A(A), .B(B),
    .out_valid(out_valid2), .out_ready(out_ready), .result(result2),
    .zero(zero2), .parity(parity2), .acc(acc2), .op_count(op_count2)
  );

  function automatic bit [3:0] ref_op(input bit [2:0] o, input bit [3:0] a, input bit [3:0] b);
    case (o)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a | b);
      3'd4: return ~(a & b);
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model one clock, check outputs.
  task automatic step(input bit rn, input bit iv, input bit [2:0] o, input bit am,
                      input bit ac, input bit [3:0] a, input bit [3:0] b, input bit ordy);
    bit acc_ok;
    bit [3:0] beff;
    bit [3:0] f;
    rst_n = rn; in_valid = iv; op = o; acc_mode = am; acc_clear = ac;
    A = a; B = b; out_ready = ordy;
    #1;
    if (m_known) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || ordy)});
      check("in_ready2", {31'd0, in_ready2}, {31'd0, (!m_valid || ordy)});
    end
    acc_ok = iv && (!m_valid || ordy);
    @(posedge clk);
    if (!rn) begin
      m_known = 1; m_valid = 0; m_result = 0; m_zero = 0; m_parity = 0;
      m_acc = 0; m_cnt = 0;
    end else if (acc_ok) begin
      beff = am ? (ac ? 4'd0 : m_acc) : b;
      f = ref_op(o, a, beff);
      m_result = f; m_zero = (f == 0); m_parity = ^f; m_acc = f;
      m_cnt = m_cnt + 1; m_valid = 1;
    end else begin
      if (ac) m_acc = 0;
      if (ordy) m_valid = 0;
    end
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("result", {28'd0, result}, {28'd0, m_result});
    check("zero", {31'd0, zero}, {31'd0, m_zero});
    check("parity", {31'd0, parity}, {31'd0, m_parity});
    check("acc", {28'd0, acc}, {28'd0, m_acc});
    check("op_count", {24'd0, op_count}, m_cnt % 256);
    check("op_count2", {30'd0, op_count2}, m_cnt % 4);
    $display("step rst_n=%0b iv=%0b op=%0d am=%0b ac=%0b A=%h B=%h ordy=%0b -> ov=%0b res=%h z=%0b p=%0b acc=%h cnt=%0d",
             rn, iv, o, am, ac, a, b, ordy, out_valid, result, zero, parity, acc, op_count);
  endtask

  initial begin
    bit [3:0] exp_ops [8];
    exp_ops = '{4'b0010, 4'b1110, 4'b1100, 4'b0001, 4'b1101, 4'b0011, 4'b0101, 4'b1010};

    // Reset
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // OR example then second op
    step(1, 1, 3'b001, 0, 0, 4'b1100, 4'b0011, 1);
    check("or_res", {28'd0, result}, 32'hF);
    step(1, 1, 3'b001, 0, 0, 4'b0000, 4'b0011, 1);
    check("or2_res", {28'd0, result}, 32'h3);
    check("or2_cnt", {24'd0, op_count}, 32'd2);

    // All eight ops
    for (int i = 0; i < 8; i++) begin
      step(1, 1, i[2:0], 0, 0, 4'b1010, 4'b0110, 1);
      check($sformatf("op%0d_res", i), {28'd0, result}, {28'd0, exp_ops[i]});
    end
    step(1, 1, 3'b000, 0, 0, 4'b0000, 4'b0110, 1);
    check("and_zero", {31'd0, zero}, 32'd1);

    // Accumulator sequence
    step(1, 1, 3'b001, 1, 1, 4'b0001, 4'b1111, 1);
    check("acc1", {28'd0, result}, 32'h1);
    step(1, 1, 3'b001, 1, 0, 4'b0100, 4'b1111, 1);
    check("acc2", {28'd0, result}, 32'h5);
    step(1, 1, 3'b010, 1, 0, 4'b0101, 4'b1111, 1);
    check("acc3_res", {28'd0, result}, 32'h0);
    check("acc3_zero", {31'd0, zero}, 32'd1);
    // Clear without accept
    step(1, 1, 3'b111, 0, 0, 4'b0110, 4'b0000, 1);
    step(1, 0, 3'b000, 0, 1, 4'b0000, 4'b0000, 1);
    check("clr_noacc", {28'd0, acc}, 32'h0);

    // Backpressure
    step(1, 1, 3'b001, 0, 0, 4'b1100, 4'b0011, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 3'b000, 0, 0, 4'b0101, 4'b0011, 0);
      check("bp_hold", {28'd0, result}, 32'hF);
      check("bp_ready", {31'd0, in_ready}, 32'd0);
    end
    step(1, 1, 3'b000, 0, 0, 4'b0101, 4'b0011, 1);
    check("bp_thru_valid", {31'd0, out_valid}, 32'd1);
    check("bp_thru_res", {28'd0, result}, 32'h1);
    step(1, 0, 3'b000, 0, 0, 4'b0000, 4'b0000, 1);
    check("drain", {31'd0, out_valid}, 32'd0);

    // Mid-stream reset with a held result
    step(1, 1, 3'b111, 0, 0, 4'b0101, 4'b0000, 0);
    step(0, 1, 3'b111, 0, 0, 4'b1111, 4'b0000, 0);
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_acc", {28'd0, acc}, 32'h0);
    check("mrst_cnt", {24'd0, op_count}, 32'd0);
    check("mrst_ready", {31'd0, in_ready}, 32'd1);

    // Counter wrap on the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 3'b111, 0, 0, 4'b0001, 4'b0000, 1);
      check($sformatf("wrap%0d", i), {30'd0, op_count2}, (i + 1) % 4);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) != 0), $urandom_range(0, 3) != 0, 3'($urandom),
           1'($urandom), ($urandom_range(0, 5) == 0), 4'($urandom), 4'($urandom),
           $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
